// File: rtl/bp_me_pkg.sv
// Shared definitions for the DRAM channel model.
package bp_me_pkg;

  typedef enum logic [0:0] {
    e_ready,
    e_refresh
  } dram_state_e;

endpackage

// File: rtl/bsg_fifo_1r1w_small.sv
// Small one-read/one-write FIFO with registered storage and an async active-low reset.
// Data becomes visible on data_o one cycle after it is enqueued.
module bsg_fifo_1r1w_small #(
  parameter int width_p = 8,
  parameter int els_p   = 4
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic [width_p-1:0] data_i,
  input  logic               v_i,
  output logic               ready_o,
  output logic [width_p-1:0] data_o,
  output logic               v_o,
  input  logic               yumi_i
);

  localparam int ptr_w_lp = (els_p > 1) ? $clog2(els_p) : 1;
  localparam int cnt_w_lp = $clog2(els_p + 1);

  logic [width_p-1:0]  mem_r [els_p];
  logic [ptr_w_lp-1:0] rptr_r, wptr_r;
  logic [cnt_w_lp-1:0] count_r;
  logic                enq, deq;

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [ptr_w_lp-1:0] bump(input logic [ptr_w_lp-1:0] p);
    return (p == ptr_w_lp'(els_p - 1)) ? '0 : p + ptr_w_lp'(1);
  endfunction

  assign ready_o = (count_r != cnt_w_lp'(els_p));
  assign v_o     = (count_r != '0);
  assign enq     = v_i & ready_o;
  assign deq     = yumi_i & v_o;
  assign data_o  = mem_r[rptr_r];

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rptr_r  <= '0;
      wptr_r  <= '0;
      count_r <= '0;
    end else begin
      if (enq) wptr_r <= bump(wptr_r);
      if (deq) rptr_r <= bump(rptr_r);
      count_r <= count_r + cnt_w_lp'(enq) - cnt_w_lp'(deq);
    end
  end

  always_ff @(posedge clk_i) begin
    if (enq) mem_r[wptr_r] <= data_i;
  end

endmodule

// File: rtl/bp_dram_channel_model.sv
// Behavioural DRAM channel: byte-masked writes, fixed-latency reads with credit flow control,
// and periodic refresh windows that block new commands.
module bp_dram_channel_model
  import bp_me_pkg::*;
#(
  parameter int channel_addr_width_p = 32,
  parameter int data_width_p         = 64,
  parameter int mem_els_p            = 1024,
  parameter int read_latency_p       = 4,
  parameter int resp_els_p           = 4,
  parameter int refresh_interval_p   = 256,
  parameter int refresh_cycles_p     = 8
) (
  input  logic                            dram_clk_i,
  input  logic                            dram_reset_n_i,
  input  logic [channel_addr_width_p-1:0] dram_ch_addr_i,
  input  logic                            dram_write_not_read_i,
  input  logic                            dram_v_i,
  output logic                            dram_yumi_o,
  input  logic [data_width_p-1:0]         dram_data_i,
  input  logic [data_width_p/8-1:0]       dram_mask_i,
  input  logic                            dram_data_v_i,
  output logic                            dram_data_yumi_o,
  output logic [data_width_p-1:0]         dram_data_o,
  output logic [channel_addr_width_p-1:0] dram_ch_addr_o,
  output logic                            dram_data_v_o,
  input  logic                            dram_data_ready_i
);

  localparam int mask_w_lp   = data_width_p / 8;
  localparam int byte_off_lp = $clog2(mask_w_lp);
  localparam int idx_w_lp    = (mem_els_p > 1) ? $clog2(mem_els_p) : 1;
  localparam int credit_w_lp = $clog2(resp_els_p + 1);
  localparam int ref_max_lp  = (refresh_interval_p > refresh_cycles_p) ? refresh_interval_p : refresh_cycles_p;
  localparam int ref_w_lp    = $clog2(ref_max_lp + 1);
  localparam int entry_w_lp  = channel_addr_width_p + data_width_p;

  dram_state_e                   state_r, state_n;
  logic [ref_w_lp-1:0]           ref_cnt_r, ref_cnt_n;
  logic [credit_w_lp-1:0]        credits_r;
  logic                          wr_accept, rd_accept, rsp_deq;
  logic [channel_addr_width_p-1:0] word_addr;
  logic [idx_w_lp-1:0]           idx;

  logic [data_width_p-1:0]         mem_r       [mem_els_p];
  logic [read_latency_p-1:0]       pipe_v_r;
  logic [data_width_p-1:0]         pipe_data_r [read_latency_p];
  logic [channel_addr_width_p-1:0] pipe_addr_r [read_latency_p];

  logic                  fifo_ready;
  logic [entry_w_lp-1:0] fifo_data;

  assign word_addr = dram_ch_addr_i >> byte_off_lp;
  assign idx       = idx_w_lp'(word_addr % channel_addr_width_p'(mem_els_p));
  assign rsp_deq   = dram_data_v_o & dram_data_ready_i;

  always_ff @(posedge dram_clk_i or negedge dram_reset_n_i) begin
    if (!dram_reset_n_i) begin
      state_r   <= e_ready;
      ref_cnt_r <= '0;
    end else begin
      state_r   <= state_n;
      ref_cnt_r <= ref_cnt_n;
    end
  end

  // Commands are only taken outside refresh and never while reset is asserted.
  always_comb begin
    state_n   = state_r;
    ref_cnt_n = ref_cnt_r + ref_w_lp'(1);
    wr_accept = 1'b0;
    rd_accept = 1'b0;
    case (state_r)
      e_ready: begin
        wr_accept = dram_reset_n_i & dram_v_i & dram_write_not_read_i & dram_data_v_i;
        rd_accept = dram_reset_n_i & dram_v_i & ~dram_write_not_read_i
                    & (credits_r < credit_w_lp'(resp_els_p));
        if (ref_cnt_r == ref_w_lp'(refresh_interval_p - 1)) begin
          state_n   = e_refresh;
          ref_cnt_n = '0;
        end
      end
      e_refresh: begin
        if (ref_cnt_r == ref_w_lp'(refresh_cycles_p - 1)) begin
          state_n   = e_ready;
          ref_cnt_n = '0;
        end
      end
      default: begin
        state_n   = e_ready;
        ref_cnt_n = '0;
      end
    endcase
  end

  assign dram_yumi_o      = wr_accept | rd_accept;
  assign dram_data_yumi_o = wr_accept;

  always_ff @(posedge dram_clk_i or negedge dram_reset_n_i) begin
    if (!dram_reset_n_i) begin
      credits_r <= '0;
    end else begin
      case ({rd_accept, rsp_deq})
        2'b10:   credits_r <= credits_r + credit_w_lp'(1);
        2'b01:   credits_r <= credits_r - credit_w_lp'(1);
        default: credits_r <= credits_r;
      endcase
    end
  end

  always_ff @(posedge dram_clk_i or negedge dram_reset_n_i) begin
    if (!dram_reset_n_i) begin
      pipe_v_r <= '0;
    end else begin
      pipe_v_r[0] <= rd_accept;
      for (int s = 1; s < read_latency_p; s++) pipe_v_r[s] <= pipe_v_r[s-1];
    end
  end

  // Read data is captured at the accept edge, so a write one cycle earlier is already visible.
  always_ff @(posedge dram_clk_i) begin
    if (wr_accept) begin
      for (int b = 0; b < mask_w_lp; b++) begin
        if (dram_mask_i[b]) mem_r[idx][b*8 +: 8] <= dram_data_i[b*8 +: 8];
      end
    end
    if (rd_accept) begin
      pipe_data_r[0] <= mem_r[idx];
      pipe_addr_r[0] <= dram_ch_addr_i;
    end
    for (int s = 1; s < read_latency_p; s++) begin
      pipe_data_r[s] <= pipe_data_r[s-1];
      pipe_addr_r[s] <= pipe_addr_r[s-1];
    end
  end

  // Credits bound pipeline plus queue occupancy, so the queue never refuses an entry.
  bsg_fifo_1r1w_small #(
    .width_p (entry_w_lp),
    .els_p   (resp_els_p)
  ) resp_fifo (
    .clk_i     (dram_clk_i),
    .reset_n_i (dram_reset_n_i),
    .data_i    ({pipe_addr_r[read_latency_p-1], pipe_data_r[read_latency_p-1]}),
    .v_i       (pipe_v_r[read_latency_p-1] & fifo_ready),
    .ready_o   (fifo_ready),
    .data_o    (fifo_data),
    .v_o       (dram_data_v_o),
    .yumi_i    (rsp_deq)
  );

  assign {dram_ch_addr_o, dram_data_o} = fifo_data;

endmodule

// File: tb/tb_bp_dram_channel_model.sv
// Scoreboard bench for the DRAM channel model: a word-array reference model predicts
// acceptance per cycle and the read data each accepted read must return.
module tb_bp_dram_channel_model;

  localparam int AW       = 16;
  localparam int DW       = 64;
  localparam int MEM_ELS  = 64;
  localparam int LAT      = 4;
  localparam int ELS      = 4;
  localparam int INTERVAL = 100;
  localparam int RCYC     = 8;
  localparam int PERIOD   = INTERVAL + RCYC;

  logic          clk, rst_n;
  logic [AW-1:0] ch_addr;
  logic          wnr, v, yumi;
  logic [DW-1:0] wdata;
  logic [7:0]    mask;
  logic          data_v, data_yumi;
  logic [DW-1:0] rdata;
  logic [AW-1:0] raddr;
  logic          rdata_v, data_ready;

  bp_dram_channel_model #(
    .channel_addr_width_p (AW),
    .data_width_p         (DW),
    .mem_els_p            (MEM_ELS),
    .read_latency_p       (LAT),
    .resp_els_p           (ELS),
    .refresh_interval_p   (INTERVAL),
    .refresh_cycles_p     (RCYC)
  ) dut (
    .dram_clk_i            (clk),
    .dram_reset_n_i        (rst_n),
    .dram_ch_addr_i        (ch_addr),
    .dram_write_not_read_i (wnr),
    .dram_v_i              (v),
    .dram_yumi_o           (yumi),
    .dram_data_i           (wdata),
    .dram_mask_i           (mask),
    .dram_data_v_i         (data_v),
    .dram_data_yumi_o      (data_yumi),
    .dram_data_o           (rdata),
    .dram_ch_addr_o        (raddr),
    .dram_data_v_o         (rdata_v),
    .dram_data_ready_i     (data_ready)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    bit            check_lat;
    int            acc_cyc;
  } rsp_t;

  rsp_t          sb[$];
  logic [DW-1:0] model_mem [MEM_ELS];
  int            checks, errors;
  int            cyc, outstanding;
  int            rd_yumi_seen, dyumi_seen, rsp_seen;
  bit            lat_mode, rand_ready;
  logic [DW-1:0] last_rsp_data;
  logic [AW-1:0] last_rsp_addr;
  bit            hold_v;
  logic [DW-1:0] hold_data;
  logic [AW-1:0] hold_addr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  always @(posedge clk) begin
    if (rand_ready) begin
      #1;
      data_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic check_output(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int word_of(input logic [AW-1:0] a);
    return int'(a >> 3) % MEM_ELS;
  endfunction

  // Reference model: refresh windows follow from the cycle count, credits from outstanding reads.
  always @(negedge clk) begin
    bit   in_ref, exp_wr, exp_rd;
    rsp_t e;
    if (!rst_n) begin
      outstanding = 0;
      sb.delete();
      check_output("reset_yumi", {yumi, data_yumi}, 0);
    end else begin
      in_ref = (cyc % PERIOD) >= INTERVAL;
      exp_wr = !in_ref && v && wnr && data_v;
      exp_rd = !in_ref && v && !wnr && (outstanding < ELS);
      if (v || data_v) begin
        check_output("yumi", yumi, exp_wr || exp_rd);
        check_output("data_yumi", data_yumi, exp_wr);
      end
      if (yumi && !wnr) rd_yumi_seen++;
      if (data_yumi) dyumi_seen++;
      if (exp_wr) begin
        for (int b = 0; b < 8; b++)
          if (mask[b]) model_mem[word_of(ch_addr)][b*8 +: 8] = wdata[b*8 +: 8];
      end
      if (exp_rd) begin
        e.addr      = ch_addr;
        e.data      = model_mem[word_of(ch_addr)];
        e.check_lat = lat_mode && (outstanding == 0);
        e.acc_cyc   = cyc;
        sb.push_back(e);
        outstanding++;
      end
      if (rdata_v && data_ready && outstanding > 0) outstanding--;
    end
  end

  // Response monitor: pops the scoreboard on every handshake.
  always @(negedge clk) begin
    rsp_t e;
    if (!rst_n) begin
      check_output("reset_data_v", rdata_v, 0);
      hold_v = 1'b0;
    end else begin
      if (hold_v) begin
        check_output("hold_valid", rdata_v, 1);
        check_output("hold_data", rdata, hold_data);
        check_output("hold_addr", raddr, hold_addr);
      end
      if (rdata_v && data_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_rsp: got addr 0x%0h data 0x%0h, expected no response", raddr, rdata);
        end else begin
          e = sb.pop_front();
          check_output("rsp_data", rdata, e.data);
          check_output("rsp_addr", raddr, e.addr);
          if (e.check_lat) check_output("latency", cyc - e.acc_cyc, LAT + 1);
        end
        rsp_seen++;
        last_rsp_data = rdata;
        last_rsp_addr = raddr;
      end
      hold_v    = rdata_v && !data_ready;
      hold_data = rdata;
      hold_addr = raddr;
    end
  end

  // Presents one command and holds it until consumed; entered and left at posedge+1.
  task automatic apply_stimulus(input bit is_wr, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [7:0] m);
    int n;
    v = 1'b1; wnr = is_wr; ch_addr = a; wdata = d; mask = m; data_v = is_wr;
    n = 0;
    @(negedge clk);
    while (!yumi && n < 1000) begin
      n++;
      @(negedge clk);
    end
    if (!yumi) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout: got no yumi, expected one within 1000 cycles (addr 0x%0h)", a);
    end
    @(posedge clk); #1;
    v = 1'b0; data_v = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < 2000) begin
      @(posedge clk);
      n++;
    end
    @(posedge clk); #1;
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain_timeout: got %0d pending responses, expected 0", sb.size());
    end
  endtask

  // Issues n reads with the sink stalled and checks how many are taken before it reopens.
  task automatic credit_burst(input int n, input int exp_taken, input int stall);
    int base_yumi = rd_yumi_seen;
    int base_rsp  = rsp_seen;
    data_ready = 1'b0;
    fork
      for (int i = 0; i < n; i++) apply_stimulus(0, AW'($urandom), '0, '0);
      begin
        idle(stall);
        check_output("credit_limit", rd_yumi_seen - base_yumi, exp_taken);
        data_ready = 1'b1;
      end
    join
    wait_drain();
    check_output("burst_rsp_count", rsp_seen - base_rsp, n);
  endtask

  initial begin
    int base;
    checks = 0; errors = 0;
    rd_yumi_seen = 0; dyumi_seen = 0; rsp_seen = 0;
    lat_mode = 0; rand_ready = 0; hold_v = 0;
    rst_n = 1'b0; data_ready = 1'b1;
    v = 1'b1; wnr = 1'b1; data_v = 1'b1; ch_addr = '0; wdata = '1; mask = '1;
    repeat (3) @(posedge clk);
    #1;
    v = 1'b0; data_v = 1'b0;
    rst_n = 1'b1;

    for (int i = 0; i < MEM_ELS; i++)
      apply_stimulus(1, AW'(i * 8), {$urandom, $urandom}, 8'hFF);

    lat_mode = 1;
    apply_stimulus(1, 16'h0040, 64'h1122334455667788, 8'hFF);
    apply_stimulus(0, 16'h0040, '0, '0);
    wait_drain();
    check_output("full_write_data", last_rsp_data, 64'h1122334455667788);
    check_output("full_write_addr", last_rsp_addr, 16'h0040);

    apply_stimulus(1, 16'h0040, 64'hAAAAAAAAAAAAAAAA, 8'h0F);
    apply_stimulus(0, 16'h0040, '0, '0);
    wait_drain();
    check_output("masked_write_data", last_rsp_data, 64'h11223344AAAAAAAA);

    apply_stimulus(0, 16'h0045, '0, '0);
    wait_drain();
    check_output("offset_addr_echo", last_rsp_addr, 16'h0045);
    check_output("offset_data", last_rsp_data, 64'h11223344AAAAAAAA);

    apply_stimulus(0, 16'h0240, '0, '0);
    wait_drain();
    check_output("wrap_data", last_rsp_data, 64'h11223344AAAAAAAA);

    for (int i = 0; i < 4; i++) apply_stimulus(0, AW'(i * 8), '0, '0);
    wait_drain();
    lat_mode = 0;

    credit_burst(6, ELS, 20);

    base = dyumi_seen;
    data_v = 1'b1; wdata = 64'hDEADBEEFCAFEF00D; mask = 8'hFF;
    idle(6);
    check_output("orphan_data", dyumi_seen - base, 0);
    apply_stimulus(1, 16'h0100, 64'hDEADBEEFCAFEF00D, 8'hFF);
    check_output("data_with_cmd", dyumi_seen - base, 1);

    for (int i = 0; i < 250; i++)
      apply_stimulus(i[0], AW'($urandom_range(0, 1023)), {$urandom, $urandom}, 8'hFF);
    wait_drain();

    rand_ready = 1;
    for (int i = 0; i < 300; i++) begin
      apply_stimulus($urandom_range(0, 1) == 1, AW'($urandom), {$urandom, $urandom}, 8'($urandom_range(0, 255)));
      idle($urandom_range(0, 2));
    end
    rand_ready = 0;
    @(posedge clk); #2;
    data_ready = 1'b1;
    wait_drain();

    for (int i = 0; i < 3; i++) apply_stimulus(0, AW'(i * 8 + 3), '0, '0);
    #2;
    rst_n = 1'b0;
    base = rsp_seen;
    idle(3);
    rst_n = 1'b1;
    idle(12);
    check_output("no_rsp_after_reset", rsp_seen - base, 0);
    lat_mode = 1;
    apply_stimulus(0, 16'h0040, '0, '0);
    wait_drain();
    check_output("post_reset_addr", last_rsp_addr, 16'h0040);
    lat_mode = 0;
    credit_burst(ELS, ELS, 12);

    idle(5);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no completion, expected finish before 500000 time units");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
